// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage core pipeline controller:
//   - stall vector bit indices (bit0 PC .. bit5 WB)
//   - encoded stall vectors, one per deepest requesting stage
//   - the ERET exception code and the flush/stall/reset polarity names
//   - the controller FSM state type
// No ports; this file holds constants and types only.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Bit positions inside the stall vector.
    localparam int STALL_PC_BIT  = 0;
    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_ID_BIT  = 2;
    localparam int STALL_EX_BIT  = 3;
    localparam int STALL_MEM_BIT = 4;
    localparam int STALL_WB_BIT  = 5;

    // A stage that stalls also freezes every stage in front of it, so each
    // encoded vector is a run of ones from PC up to the requesting stage.
    // WB is never frozen: the instruction already past MEM retires.
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [31:0] EXC_ERET  = 32'h0000_000e;

    localparam logic        FLUSH         = 1'b1;
    localparam logic        NO_FLUSH      = 1'b0;
    localparam logic        STALL_ENABLE  = 1'b1;
    localparam logic        STALL_DISABLE = 1'b0;
    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    // RUN: normal operation, flushes may be raised.
    // RECOVER: the cycle right after a flush; MEM holds a bubble, so no new
    // flush can be raised, but stall requests are still honoured.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones and holds there, never wrapping.
// Ports:
//   clk     in   1  clock
//   rst     in   1  synchronous reset, active-high, clears the count
//   clear   in   1  synchronous clear, wins over enable
//   enable  in   1  count one step this cycle (ignored once saturated)
//   count   out  W  current registered count
// -----------------------------------------------------------------------------
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear) begin
            count <= '0;
        end else if (enable && count != CNT_MAX) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central pipeline controller for the 5-stage core. Merges per-stage stall
// requests into one stall vector, turns MEM-stage exceptions and memory-bus
// watchdog timeouts into a one-cycle flush with a redirect PC, and keeps
// saturating stall/flush performance counters.
//
// Interface timing: there is no handshake. stall, flush, new_pc and
// bus_timeout are level signals, combinational from the inputs and the
// current state, and are sampled by the pipeline registers on the same clk
// edge. stall_cycles and flush_count are registered and show an event the
// cycle after it happens.
//
// Ports:
//   clk           in   1   clock
//   rst           in   1   synchronous reset, active-high
//   stallreq_if   in   1   instruction-bus wait
//   stallreq_id   in   1   load-use hazard
//   stallreq_ex   in   1   multi-cycle EX op busy
//   stallreq_mem  in   1   data-bus wait
//   excepttype_i  in   32  MEM-stage exception code, 0 = none, 0xe = ERET
//   cp0_epc_i     in   32  EPC from CP0, the ERET target
//   stall         out  6   per-stage stall vector (bit0 PC .. bit5 WB)
//   flush         out  1   pipeline flush
//   new_pc        out  32  redirect target while flush=1, otherwise 0
//   bus_timeout   out  1   pulse coinciding with a watchdog flush
//   stall_cycles  out  32  cycles with stall!=0, saturating
//   flush_count   out  16  flush cycles, saturating
//   fsm_state     out  1   controller state, for observation only
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
    parameter logic [31:0] BUSERR_VECTOR  = 32'h0000_0040,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        bus_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output pipe_state_e fsm_state
);

    pipe_state_e state;
    pipe_state_e state_next;
    logic [15:0] wd_count;
    logic        wd_expired;

    // The watchdog has already counted TIMEOUT_CYCLES-1 stalled cycles, so
    // this cycle is the TIMEOUT_CYCLES-th consecutive one.
    assign wd_expired = stallreq_mem && (wd_count == (TIMEOUT_CYCLES - 16'd1));

    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, flush mux and stall priority encoder
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        flush       = NO_FLUSH;
        new_pc      = ZERO_WORD;
        bus_timeout = 1'b0;
        stall       = STALL_NONE;

        if (rst != RST_ENABLE) begin
            // Flush sources in priority order. An exception in the same
            // cycle as a timeout takes the exception path, so bus_timeout
            // stays low and the watchdog is cleared by the flush anyway.
            if (state == ST_RUN) begin
                if (excepttype_i == EXC_ERET) begin
                    flush  = FLUSH;
                    new_pc = cp0_epc_i;
                end else if (excepttype_i != ZERO_WORD) begin
                    flush  = FLUSH;
                    new_pc = EXC_VECTOR;
                end else if (wd_expired) begin
                    flush       = FLUSH;
                    new_pc      = BUSERR_VECTOR;
                    bus_timeout = 1'b1;
                end
            end

            // A flush empties the pipe, so nothing may be held that cycle.
            if (flush == NO_FLUSH) begin
                if (stallreq_mem) begin
                    stall = STALL_MEM;
                end else if (stallreq_ex) begin
                    stall = STALL_EX;
                end else if (stallreq_id) begin
                    stall = STALL_ID;
                end else if (stallreq_if) begin
                    stall = STALL_IF;
                end
            end

            unique case (state)
                ST_RUN:     state_next = (flush == FLUSH) ? ST_RECOVER : ST_RUN;
                ST_RECOVER: state_next = ST_RUN;
                default:    state_next = ST_RUN;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    // Watchdog: counts consecutive MEM-stall cycles; any gap or flush restarts it.
    sat_counter #(.W(16)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!stallreq_mem || flush),
        .enable (stallreq_mem && !flush),
        .count  (wd_count)
    );

    sat_counter #(.W(32)) u_stall_cycles (
        .clk    (clk),
        .rst    (rst),
        .clear  (1'b0),
        .enable (stall != STALL_NONE),
        .count  (stall_cycles)
    );

    sat_counter #(.W(16)) u_flush_count (
        .clk    (clk),
        .rst    (rst),
        .clear  (1'b0),
        .enable (flush),
        .count  (flush_count)
    );

endmodule
